// File: rtl/ren_params.sv
// ---------------------------------------------------------------------------
// ren_params: shared definitions for the 22-bit rendering float format.
//   Format : bit21 sign, bits[20:14] exponent (bias 63), bits[13:0] mantissa
//            with hidden leading 1. Exponent 0 reads as zero.
//   Holds  : opcode encodings, field widths, bias, common constants, the
//            lane ALU operation select, the fp_simd FSM state type and two
//            small helpers (leading-one position, result packing).
// ---------------------------------------------------------------------------
package ren_params;

  localparam int FP_LANE_W = 22;
  localparam int EXP_W     = 7;
  localparam int MAN_W     = 14;
  localparam int EXP_BIAS  = 63;

  localparam logic [2:0] op_add        = 3'd0;
  localparam logic [2:0] op_sub        = 3'd1;
  localparam logic [2:0] op_mul        = 3'd2;
  localparam logic [2:0] op_reduce_add = 3'd3;

  localparam logic [FP_LANE_W-1:0] fpHALF      = 22'h0F8000;
  localparam logic [FP_LANE_W-1:0] fpONE       = 22'h0FC000;
  localparam logic [FP_LANE_W-1:0] fpONEHALF   = 22'h0FE000;
  localparam logic [FP_LANE_W-1:0] fpTWO       = 22'h100000;
  localparam logic [FP_LANE_W-1:0] fpTWOHALF   = 22'h101000;
  localparam logic [FP_LANE_W-1:0] fpTHREE     = 22'h102000;
  localparam logic [FP_LANE_W-1:0] fpTHREEHALF = 22'h103000;
  localparam logic [FP_LANE_W-1:0] fpFOUR      = 22'h104000;

  typedef enum logic [1:0] {
    ALU_ADD = 2'd0,
    ALU_SUB = 2'd1,
    ALU_MUL = 2'd2
  } alu_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RED1 = 2'd2,
    RED2 = 2'd3
  } fsm_state_e;

  // Position of the most significant set bit (0 when the input is zero).
  function automatic logic [4:0] lead_one18(input logic [17:0] v);
    logic [4:0] pos;
    pos = 5'd0;
    for (int i = 0; i < 18; i++) begin
      if (v[i]) begin
        pos = i[4:0];
      end else begin
        pos = pos;
      end
    end
    return pos;
  endfunction

  // Assemble a result: underflow flushes to +0, overflow saturates to the
  // largest finite magnitude with the sign kept.
  function automatic logic [FP_LANE_W-1:0] fp_pack(input logic              sign,
                                                   input logic signed [9:0] exp,
                                                   input logic [MAN_W-1:0]  man);
    logic [FP_LANE_W-1:0] r;
    if (exp < 10'sd1) begin
      r = '0;
    end else if (exp > 10'sd127) begin
      r = {sign, {EXP_W{1'b1}}, {MAN_W{1'b1}}};
    end else begin
      r = {sign, exp[EXP_W-1:0], man};
    end
    return r;
  endfunction

endpackage

// File: rtl/fp22_alu.sv
// ---------------------------------------------------------------------------
// fp22_alu: combinational add / sub / mul on one 22-bit lane, truncating
// toward zero.
//   a_i, b_i : operands
//   op_i     : ALU_ADD, ALU_SUB (add with b's sign flipped) or ALU_MUL
//   res_o    : result; any zero result is +0 (all bits clear)
// ---------------------------------------------------------------------------
module fp22_alu
  import ren_params::*;
(
  input  logic [FP_LANE_W-1:0] a_i,
  input  logic [FP_LANE_W-1:0] b_i,
  input  alu_op_e              op_i,
  output logic [FP_LANE_W-1:0] res_o
);

  logic                  a_zero, b_zero, b_sign, swap, s_zero;
  logic                  sl, ss, sticky;
  logic [EXP_W-1:0]      el, es, ediff;
  logic [MAN_W:0]        ml, ms;
  logic [33:0]           s_wide;
  logic [16:0]           s_al;
  logic [17:0]           sum, norm;
  logic [4:0]            lead;
  logic signed [9:0]     add_exp, mul_exp;
  logic [29:0]           prod;
  logic [MAN_W-1:0]      mul_man;
  logic [FP_LANE_W-1:0]  add_res, mul_res;
  logic                  unused_bits;

  // Adder: order by magnitude, align the smaller operand with two guard bits
  // plus a sticky bit so the difference is floored exactly before truncation.
  always_comb begin
    a_zero = (a_i[20:14] == 7'd0);
    b_zero = (b_i[20:14] == 7'd0);
    b_sign = b_i[21] ^ (op_i == ALU_SUB);
    swap   = (b_i[20:0] > a_i[20:0]);
    if (swap) begin
      el = b_i[20:14]; ml = {1'b1, b_i[13:0]}; sl = b_sign;
      es = a_i[20:14]; ms = {1'b1, a_i[13:0]}; ss = a_i[21];
      s_zero = a_zero;
    end else begin
      el = a_i[20:14]; ml = {1'b1, a_i[13:0]}; sl = a_i[21];
      es = b_i[20:14]; ms = {1'b1, b_i[13:0]}; ss = b_sign;
      s_zero = b_zero;
    end
    ediff  = el - es;
    s_wide = {ms, 2'b00, 17'd0} >> ediff;
    s_al   = s_wide[33:17];
    sticky = (ediff > 7'd33) ? 1'b1 : (|s_wide[16:0]);
    if (sl == ss) begin
      sum = {1'b0, ml, 2'b00} + {1'b0, s_al};
    end else begin
      // Borrow the sticky bit so the result is floor(L - S), not L - floor(S).
      sum = {1'b0, ml, 2'b00} - {1'b0, s_al} - {17'd0, sticky};
    end
    lead    = lead_one18(sum);
    norm    = sum << (5'd17 - lead);
    add_exp = $signed({3'b000, el}) + $signed({5'b00000, lead}) - 10'sd16;
    if (a_zero && b_zero) begin
      add_res = '0;
    end else if (s_zero) begin
      add_res = {sl, el, ml[MAN_W-1:0]};
    end else if (sum == 18'd0) begin
      add_res = '0;
    end else begin
      add_res = fp_pack(sl, add_exp, norm[16:3]);
    end
  end

  // Multiplier: 15x15 mantissa product renormalises by at most one place.
  always_comb begin
    prod    = {15'd0, 1'b1, a_i[13:0]} * {15'd0, 1'b1, b_i[13:0]};
    mul_man = prod[29] ? prod[28:15] : prod[27:14];
    mul_exp = $signed({3'b000, a_i[20:14]}) + $signed({3'b000, b_i[20:14]})
              - 10'sd63 + (prod[29] ? 10'sd1 : 10'sd0);
    if (a_zero || b_zero) begin
      mul_res = '0;
    end else begin
      mul_res = fp_pack(a_i[21] ^ b_i[21], mul_exp, mul_man);
    end
  end

  // Result select.
  always_comb begin
    case (op_i)
      ALU_ADD, ALU_SUB: res_o = add_res;
      ALU_MUL:          res_o = mul_res;
      default:          res_o = '0;
    endcase
  end

  assign unused_bits = ^{norm[17], norm[2:0], prod[13:0]};

endmodule

// File: rtl/fp_simd.sv
// ---------------------------------------------------------------------------
// fp_simd: 4-lane SIMD add/sub/mul and horizontal reduce-add on 22-bit floats.
//   clk      : rising-edge clock
//   rst_n    : synchronous reset, active HIGH despite the name
//   i_en     : start request, sampled in IDLE
//   i_in1/2  : operands, lane 0 in the top 22 bits
//   i_opcode : 0 add, 1 sub, 2 mul, 3 reduce_add, 4..7 give zero lanes
//   o_output : result register, held between operations
//   o_valid  : one-cycle pulse when o_output is written
//   o_busy   : high while an operation is in flight
// ---------------------------------------------------------------------------
module fp_simd
  import ren_params::*;
#(
  parameter int SIMD_WIDTH = 4,
  parameter int FP_W       = 22
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       i_en,
  input  logic [SIMD_WIDTH*FP_W-1:0] i_in1,
  input  logic [SIMD_WIDTH*FP_W-1:0] i_in2,
  input  logic [2:0]                 i_opcode,
  output logic [SIMD_WIDTH*FP_W-1:0] o_output,
  output logic                       o_valid,
  output logic                       o_busy
);

  fsm_state_e                        state_q;
  logic [SIMD_WIDTH*FP_W-1:0]        in1_q, in2_q, out_q;
  logic [2:0]                        op_q;
  logic [SIMD_WIDTH-1:0][FP_W-1:0]   acc_q;
  logic                              valid_q, busy_q;

  logic [SIMD_WIDTH-1:0][FP_W-1:0]   alu_a, alu_b, alu_res;
  alu_op_e                           alu_op [SIMD_WIDTH];
  alu_op_e                           lane_op;
  logic [SIMD_WIDTH*FP_W-1:0]        exec_out;

  for (genvar g = 0; g < SIMD_WIDTH; g++) begin : g_lane
    fp22_alu u_alu (
      .a_i   (alu_a[g]),
      .b_i   (alu_b[g]),
      .op_i  (alu_op[g]),
      .res_o (alu_res[g])
    );
  end

  // Lane ALU inputs: latched operands in EXEC; lanes 0/1 become the
  // reduction adders in RED1 and lane 0 alone in RED2.
  always_comb begin
    case (op_q)
      op_add:                lane_op = ALU_ADD;
      op_sub, op_reduce_add: lane_op = ALU_SUB;
      op_mul:                lane_op = ALU_MUL;
      default:               lane_op = ALU_ADD;
    endcase
    for (int i = 0; i < SIMD_WIDTH; i++) begin
      alu_a[i]  = in1_q[(SIMD_WIDTH-1-i)*FP_W +: FP_W];
      alu_b[i]  = in2_q[(SIMD_WIDTH-1-i)*FP_W +: FP_W];
      alu_op[i] = lane_op;
    end
    case (state_q)
      RED1: begin
        alu_a[0] = acc_q[0]; alu_b[0] = acc_q[1]; alu_op[0] = ALU_ADD;
        alu_a[1] = acc_q[2]; alu_b[1] = acc_q[3]; alu_op[1] = ALU_ADD;
      end
      RED2: begin
        alu_a[0] = acc_q[0]; alu_b[0] = acc_q[1]; alu_op[0] = ALU_ADD;
      end
      default: begin
        alu_a[0] = alu_a[0];
      end
    endcase
  end

  // Element-wise result vector; unsupported opcodes give all-zero lanes.
  always_comb begin
    exec_out = '0;
    for (int i = 0; i < SIMD_WIDTH; i++) begin
      if (op_q == op_add || op_q == op_sub || op_q == op_mul) begin
        exec_out[(SIMD_WIDTH-1-i)*FP_W +: FP_W] = alu_res[i];
      end else begin
        exec_out[(SIMD_WIDTH-1-i)*FP_W +: FP_W] = '0;
      end
    end
  end

  // Control FSM with registered result, valid and busy.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      state_q <= IDLE;
      in1_q   <= '0;
      in2_q   <= '0;
      op_q    <= op_add;
      acc_q   <= '0;
      out_q   <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (i_en) begin
            in1_q   <= i_in1;
            in2_q   <= i_in2;
            op_q    <= i_opcode;
            busy_q  <= 1'b1;
            state_q <= EXEC;
          end else begin
            busy_q  <= 1'b0;
          end
        end
        EXEC: begin
          if (op_q == op_reduce_add) begin
            acc_q   <= alu_res;
            state_q <= RED1;
          end else begin
            out_q   <= exec_out;
            valid_q <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end
        end
        RED1: begin
          acc_q[0] <= alu_res[0];
          acc_q[1] <= alu_res[1];
          state_q  <= RED2;
        end
        RED2: begin
          out_q   <= {alu_res[0], {((SIMD_WIDTH-1)*FP_W){1'b0}}};
          valid_q <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign o_output = out_q;
  assign o_valid  = valid_q;
  assign o_busy   = busy_q;

endmodule

// File: tb/tb_fp_simd.sv
// ---------------------------------------------------------------------------
// tb_fp_simd: scoreboard bench for fp_simd. The driver pushes the expected
// result and completion cycle for each started operation; a monitor pops and
// compares whenever o_valid is seen. Expected lanes come from an exact
// integer model of the number format.
// ---------------------------------------------------------------------------
module tb_fp_simd;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_en;
  logic [87:0] i_in1, i_in2;
  logic [2:0]  i_opcode;
  logic [87:0] o_output;
  logic        o_valid, o_busy;

  fp_simd #(.SIMD_WIDTH(4), .FP_W(22)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_en     (i_en),
    .i_in1    (i_in1),
    .i_in2    (i_in2),
    .i_opcode (i_opcode),
    .o_output (o_output),
    .o_valid  (o_valid),
    .o_busy   (o_busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [87:0] data;
    int          due;
    int          id;
  } exp_t;

  exp_t sb_q[$];
  int   n_cmp  = 0;
  int   n_bad  = 0;
  int   op_id  = 0;
  bit   prev_valid = 1'b0;

  task automatic check(input string name, input logic [87:0] act, input logic [87:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic check_int(input string name, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s: actual=%0d required=%0d", name, act, req);
    end
  endtask

  // ---------------- reference model ----------------
  // Encode sign * mag * 2^scale with truncation, flush and saturation.
  function automatic logic [21:0] enc(input bit s, input longint mag, input int scale);
    int     p, e;
    longint m;
    if (mag == 0) return 22'd0;
    p = 0;
    for (int i = 0; i < 63; i++) if (mag[i]) p = i;
    e = scale + p + 63;
    if (e < 1) return 22'd0;
    if (e > 127) return {s, 21'h1FFFFF};
    m = (p >= 14) ? (mag >>> (p - 14)) : (mag << (14 - p));
    return {s, e[6:0], m[13:0]};
  endfunction

  // op: 0 add, 1 sub, 2 mul on one lane; value = (1.mant) * 2^(exp-63).
  function automatic logic [21:0] ref_op(input logic [21:0] a, input logic [21:0] b, input int op);
    bit     sa, sb;
    int     ea, eb, emin;
    longint ma, mb, va, vb, sum;
    ea = int'(a[20:14]); eb = int'(b[20:14]);
    sa = a[21]; sb = b[21] ^ (op == 1);
    ma = longint'({1'b1, a[13:0]}); mb = longint'({1'b1, b[13:0]});
    if (op == 2) begin
      if (ea == 0 || eb == 0) return 22'd0;
      return enc(a[21] ^ b[21], ma * mb, ea + eb - 154);
    end
    if (ea == 0 && eb == 0) return 22'd0;
    if (ea == 0) return enc(sb, mb, eb - 77);
    if (eb == 0) return enc(sa, ma, ea - 77);
    emin = (ea < eb) ? ea : eb;
    va = ma << (ea - emin); if (sa) va = -va;
    vb = mb << (eb - emin); if (sb) vb = -vb;
    sum = va + vb;
    if (sum < 0) return enc(1'b1, -sum, emin - 77);
    return enc(1'b0, sum, emin - 77);
  endfunction

  function automatic logic [87:0] ref_vec(input logic [87:0] a, input logic [87:0] b, input logic [2:0] op);
    logic [21:0] d [4];
    logic [87:0] r;
    r = '0;
    if (op > 3'd3) return r;
    for (int i = 0; i < 4; i++)
      d[i] = ref_op(a[(3-i)*22 +: 22], b[(3-i)*22 +: 22], (op == 3'd3) ? 1 : int'(op));
    if (op == 3'd3) r[87:66] = ref_op(ref_op(d[0], d[1], 0), ref_op(d[2], d[3], 0), 0);
    else for (int i = 0; i < 4; i++) r[(3-i)*22 +: 22] = d[i];
    return r;
  endfunction

  function automatic logic [21:0] rnd_fp();
    if ($urandom_range(0, 9) == 0) return 22'd0;
    return {1'($urandom_range(0, 1)), 7'($urandom_range(55, 75)), 14'($urandom)};
  endfunction

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (o_valid) begin
      check_int("valid_gap", int'(prev_valid), 0);
      if (sb_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_valid: o_valid=1 with no operation pending, o_output=%h", o_output);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check($sformatf("result#%0d", e.id), o_output, e.data);
        check_int($sformatf("latency#%0d", e.id), cyc, e.due);
      end
    end
    prev_valid <= o_valid;
  end

  // ---------------- driver ----------------
  // Called at a negedge with the DUT idle or in its completion cycle.
  task automatic issue(input logic [87:0] a, input logic [87:0] b, input logic [2:0] op,
                       input logic [87:0] expv, input bit scramble);
    int lat, busy_cnt;
    lat = (op == 3'd3) ? 4 : 2;
    i_in1 = a; i_in2 = b; i_opcode = op; i_en = 1'b1;
    sb_q.push_back('{expv, cyc + lat, op_id});
    op_id++;
    @(negedge clk);
    i_en = 1'b0;
    busy_cnt = 0;
    while (o_busy && busy_cnt < 20) begin
      busy_cnt++;
      if (scramble) begin
        i_in1 = {rnd_fp(), rnd_fp(), rnd_fp(), rnd_fp()};
        i_in2 = {rnd_fp(), rnd_fp(), rnd_fp(), rnd_fp()};
        i_opcode = 3'($urandom);
      end
      @(negedge clk);
    end
    check_int("busy_cycles", busy_cnt, lat - 1);
  endtask

  logic [87:0] va, vb, vexp;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b1; i_en = 1'b0; i_in1 = '0; i_in2 = '0; i_opcode = 3'd0;
    repeat (3) @(negedge clk);
    check("rst_output", o_output, 88'd0);
    check_int("rst_valid", int'(o_valid), 0);
    check_int("rst_busy", int'(o_busy), 0);
    rst_n = 1'b0;
    @(negedge clk);

    // Directed vectors: in1={1.0,2.0,2.5,3.0}, in2={0.5,2.0,1.0,1.0}.
    va = {22'h0FC000, 22'h100000, 22'h101000, 22'h102000};
    vb = {22'h0F8000, 22'h100000, 22'h0FC000, 22'h0FC000};
    issue(va, vb, 3'd0, {22'h0FE000, 22'h104000, 22'h103000, 22'h104000}, 1'b1);
    issue(va, vb, 3'd2, {22'h0F8000, 22'h104000, 22'h101000, 22'h102000}, 1'b1);
    issue(va, vb, 3'd1, {22'h0F8000, 22'h000000, 22'h0FE000, 22'h100000}, 1'b0);
    issue(va, vb, 3'd3, {22'h104000, 66'd0}, 1'b1);
    issue(va, vb, 3'd5, 88'd0, 1'b0);

    // i_en held high: restarts every other edge on the same inputs.
    i_in1 = va; i_in2 = vb; i_opcode = 3'd0; i_en = 1'b1;
    for (int k = 0; k < 3; k++) begin
      sb_q.push_back('{{22'h0FE000, 22'h104000, 22'h103000, 22'h104000}, cyc + 2 + 2 * k, op_id});
      op_id++;
    end
    repeat (6) @(negedge clk);
    i_en = 1'b0;
    @(negedge clk);

    // Reset while in RED1 aborts the reduction without a valid pulse.
    i_in1 = va; i_in2 = vb; i_opcode = 3'd3; i_en = 1'b1;
    @(negedge clk);
    i_en = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("abort_output", o_output, 88'd0);
    check_int("abort_valid", int'(o_valid), 0);
    check_int("abort_busy", int'(o_busy), 0);
    rst_n = 1'b0;
    repeat (6) @(negedge clk);
    check_int("abort_idle_busy", int'(o_busy), 0);

    // Saturation, underflow flush, sign and zero handling.
    issue({22'h1E0000, 22'h028000, 22'h0FC000, 22'h000000},
          {22'h1E0000, 22'h028000, 22'h2FC000, 22'h0FE000}, 3'd2,
          {22'h1FFFFF, 22'h000000, 22'h2FC000, 22'h000000}, 1'b0);
    issue({22'h1FFFFF, 22'h3FFFFF, 22'h0FC000, 22'h0FC000},
          {22'h1FFFFF, 22'h3FFFFF, 22'h2FC000, 22'h0F8000}, 3'd0,
          {22'h1FFFFF, 22'h3FFFFF, 22'h000000, 22'h0FE000}, 1'b0);

    // Randomized operations against the model.
    for (int n = 0; n < 60; n++) begin
      logic [2:0] op;
      va = {rnd_fp(), rnd_fp(), rnd_fp(), rnd_fp()};
      vb = {rnd_fp(), rnd_fp(), rnd_fp(), rnd_fp()};
      if ($urandom_range(0, 3) == 0) vb[43:22] = va[43:22];
      op = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(4, 7)) : 3'($urandom_range(0, 3));
      vexp = ref_vec(va, vb, op);
      issue(va, vb, op, vexp, n[0]);
    end

    for (int w = 0; w < 20 && sb_q.size() != 0; w++) @(negedge clk);
    check_int("scoreboard_drained", sb_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
